test_status_monitor: RTL and testbench



---
 rtl/test_status_monitor_pkg.sv | 38 +++
 rtl/tohost_hart_tracker.sv | 65 ++++++
 rtl/test_status_monitor.sv | 144 ++++++++++++++
 tb/tb_test_status_monitor.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/test_status_monitor_pkg.sv
// Shared types and helpers for the multi-hart tohost completion monitor.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package test_status_monitor_pkg;

    // Upper bounds for the generic helpers; a hart word is zero-extended to MAX_XLEN.
    localparam int MAX_XLEN = 64;
    localparam int MAX_BUS  = 1024;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // tohost word split into the completion bit and the test code (0 means pass).
    typedef struct packed {
        logic                  done;
        logic [MAX_XLEN-2:0]   code;
    } tohost_dec_t;

    function automatic tohost_dec_t tohost_decode(input logic [MAX_XLEN-1:0] word);
        tohost_dec_t dec;
        dec.done = word[0];
        dec.code = word[MAX_XLEN-1:1];
        return dec;
    endfunction

    // Extract channel idx of the given width from a packed bus, hart 0 in the LSBs.
    function automatic logic [MAX_XLEN-1:0] hart_slice(input logic [MAX_BUS-1:0] bus,
                                                       input int unsigned       idx,
                                                       input int unsigned       width);
        logic [MAX_BUS-1:0] mask;
        mask = (MAX_BUS'(1) << width) - MAX_BUS'(1);
        return MAX_XLEN'((bus >> (idx * width)) & mask);
    endfunction

endpackage

// File: rtl/tohost_hart_tracker.sv
// Per-hart completion tracker: latches done, fail and the failing test code.
// Latency: latched flags visible one cycle after the sampled tohost word.
// Backpressure: none; once done, the hart's tohost is ignored until the next run.
module tohost_hart_tracker
    import test_status_monitor_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                run_clear,
    input  logic                run_active,
    input  logic [MAX_XLEN-1:0] word,
    output logic                done_o,
    output logic                fail_o,
    output logic [XLEN-2:0]     code_o,
    output logic                done_now,
    output logic                fail_now
);

    tohost_dec_t     dec;
    logic            done_q, done_d;
    logic            fail_q, fail_d;
    logic [XLEN-2:0] code_q, code_d;

    assign dec = tohost_decode(word);

    // Detect this cycle's completion and compute the next latch contents.
    always_comb begin
        done_now = run_active && !done_q && dec.done;
        fail_now = done_now && (dec.code != '0);
        done_d   = done_q;
        fail_d   = fail_q;
        code_d   = code_q;
        if (run_clear) begin
            done_d = 1'b0;
            fail_d = 1'b0;
            code_d = '0;
        end else if (done_now) begin
            done_d = 1'b1;
            if (fail_now) begin
                fail_d = 1'b1;
                code_d = dec.code[XLEN-2:0];
            end
        end
    end

    // Latch registers, cleared by reset and at the start of every run.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            done_q <= 1'b0;
            fail_q <= 1'b0;
            code_q <= '0;
        end else begin
            done_q <= done_d;
            fail_q <= fail_d;
            code_q <= code_d;
        end
    end

    assign done_o = done_q;
    assign fail_o = fail_q;
    assign code_o = code_q;

endmodule

// File: rtl/test_status_monitor.sv
// Multi-hart ISA test monitor: run FSM, watchdog, cycle count, sticky aggregate result.
// Latency: DONE one edge after the last completion or the watchdog cycle; all outputs registered.
// Backpressure: none; io_start honoured only in IDLE, io_clear only in DONE.
module test_status_monitor
    import test_status_monitor_pkg::*;
#(
    parameter int          NUM_HARTS      = 4,
    parameter int          XLEN           = 32,
    parameter int          CYCLE_WIDTH    = 32,
    parameter int unsigned TIMEOUT_CYCLES = 100
) (
    input  logic                                    clock,
    input  logic                                    reset_n,
    input  logic                                    io_start,
    input  logic                                    io_clear,
    input  logic [NUM_HARTS*XLEN-1:0]               io_tohost,
    output logic                                    io_busy,
    output logic                                    io_done,
    output logic                                    io_passed,
    output logic                                    io_timeout,
    output logic [NUM_HARTS-1:0]                    io_hart_done,
    output logic [NUM_HARTS-1:0]                    io_hart_fail,
    output logic [((NUM_HARTS>1)?$clog2(NUM_HARTS):1)-1:0] io_fail_hart,
    output logic [XLEN-2:0]                         io_fail_code,
    output logic [CYCLE_WIDTH-1:0]                  io_cycles
);

    localparam int                     FH_W    = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1;
    localparam bit                     TO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [CYCLE_WIDTH-1:0] TO_LAST = CYCLE_WIDTH'(TO_EN ? TIMEOUT_CYCLES - 1 : 0);

    state_e                 state_q, state_d;
    logic [CYCLE_WIDTH-1:0] cycles_q, cycles_d;
    logic                   timeout_q, timeout_d;
    logic                   fail_vld_q, fail_vld_d;
    logic [FH_W-1:0]        fail_hart_q, fail_hart_d;

    logic                   run_clear, run_active;
    logic [MAX_BUS-1:0]     tohost_ext;
    logic [NUM_HARTS-1:0]   hart_done, hart_fail, done_now, fail_now;
    logic [XLEN-2:0]        hart_code [NUM_HARTS];
    logic                   all_done_now, timeout_hit;
    logic [FH_W-1:0]        first_fail;

    assign run_clear  = (state_q == ST_IDLE) && io_start;
    assign run_active = (state_q == ST_RUN);
    assign tohost_ext = MAX_BUS'(io_tohost);

    for (genvar h = 0; h < NUM_HARTS; h++) begin : g_hart
        logic [MAX_XLEN-1:0] word;
        assign word = hart_slice(tohost_ext, h, XLEN);

        tohost_hart_tracker #(.XLEN(XLEN)) u_trk (
            .clock      (clock),
            .reset_n    (reset_n),
            .run_clear  (run_clear),
            .run_active (run_active),
            .word       (word),
            .done_o     (hart_done[h]),
            .fail_o     (hart_fail[h]),
            .code_o     (hart_code[h]),
            .done_now   (done_now[h]),
            .fail_now   (fail_now[h])
        );
    end

    // Lowest-index failing hart among this cycle's new failures.
    always_comb begin
        first_fail = '0;
        for (int i = NUM_HARTS - 1; i >= 0; i--) begin
            if (fail_now[i]) first_fail = FH_W'(i);
        end
    end

    // Completion counts this cycle's new dones, so it beats the watchdog on a tie.
    assign all_done_now = &(hart_done | done_now);
    assign timeout_hit  = TO_EN && run_active && (cycles_q == TO_LAST) && !all_done_now;

    // FSM, saturating run counter and first-failure record.
    always_comb begin
        state_d     = state_q;
        cycles_d    = cycles_q;
        timeout_d   = timeout_q;
        fail_vld_d  = fail_vld_q;
        fail_hart_d = fail_hart_q;
        case (state_q)
            ST_IDLE: begin
                if (io_start) begin
                    state_d     = ST_RUN;
                    cycles_d    = '0;
                    timeout_d   = 1'b0;
                    fail_vld_d  = 1'b0;
                    fail_hart_d = '0;
                end
            end
            ST_RUN: begin
                if (cycles_q != '1) cycles_d = cycles_q + 1'b1;
                if (!fail_vld_q && (|fail_now)) begin
                    fail_vld_d  = 1'b1;
                    fail_hart_d = first_fail;
                end
                if (all_done_now) begin
                    state_d = ST_DONE;
                end else if (timeout_hit) begin
                    state_d   = ST_DONE;
                    timeout_d = 1'b1;
                end
            end
            ST_DONE: begin
                if (io_clear) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Top-level state registers; reset discards any partial run.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            cycles_q    <= '0;
            timeout_q   <= 1'b0;
            fail_vld_q  <= 1'b0;
            fail_hart_q <= '0;
        end else begin
            state_q     <= state_d;
            cycles_q    <= cycles_d;
            timeout_q   <= timeout_d;
            fail_vld_q  <= fail_vld_d;
            fail_hart_q <= fail_hart_d;
        end
    end

    // Outputs are decoded from registers only.
    assign io_busy      = (state_q == ST_RUN);
    assign io_done      = (state_q == ST_DONE);
    assign io_passed    = io_done && !timeout_q && (hart_fail == '0);
    assign io_timeout   = timeout_q;
    assign io_hart_done = hart_done;
    assign io_hart_fail = hart_fail;
    assign io_fail_hart = fail_hart_q;
    assign io_fail_code = fail_vld_q ? hart_code[fail_hart_q] : '0;
    assign io_cycles    = cycles_q;

endmodule

// File: tb/tb_test_status_monitor.sv
module tb_test_status_monitor;
    import test_status_monitor_pkg::*;

    localparam int NH = 4;
    localparam int XL = 32;
    localparam int CW = 32;

    logic            clock = 1'b0;
    logic            reset_n = 1'b0;
    logic            io_start = 1'b0;
    logic            io_clear = 1'b0;
    logic [NH*XL-1:0] io_tohost = '0;
    logic            io_busy, io_done, io_passed, io_timeout;
    logic [NH-1:0]   io_hart_done, io_hart_fail;
    logic [1:0]      io_fail_hart;
    logic [XL-2:0]   io_fail_code;
    logic [CW-1:0]   io_cycles;

    test_status_monitor #(
        .NUM_HARTS(NH), .XLEN(XL), .CYCLE_WIDTH(CW), .TIMEOUT_CYCLES(100)
    ) dut (
        .clock(clock), .reset_n(reset_n), .io_start(io_start), .io_clear(io_clear),
        .io_tohost(io_tohost), .io_busy(io_busy), .io_done(io_done), .io_passed(io_passed),
        .io_timeout(io_timeout), .io_hart_done(io_hart_done), .io_hart_fail(io_hart_fail),
        .io_fail_hart(io_fail_hart), .io_fail_code(io_fail_code), .io_cycles(io_cycles)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic          passed;
        logic          timeout;
        logic [NH-1:0] hdone;
        logic [NH-1:0] hfail;
        logic [1:0]    fhart;
        logic [XL-2:0] fcode;
        logic [CW-1:0] cycles;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passes = 0;
    int   jc = 0;
    logic done_seen = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Monitor: on each DONE entry, pop the expected result and compare it.
    always @(negedge clock) begin
        if (io_done && !done_seen) begin
            done_seen = 1'b1;
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 64'(io_done), 64'(0));
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("passed",    64'(io_passed),    64'(e.passed));
                chk("timeout",   64'(io_timeout),   64'(e.timeout));
                chk("hart_done", 64'(io_hart_done), 64'(e.hdone));
                chk("hart_fail", 64'(io_hart_fail), 64'(e.hfail));
                chk("fail_hart", 64'(io_fail_hart), 64'(e.fhart));
                chk("fail_code", 64'(io_fail_code), 64'(e.fcode));
                chk("cycles",    64'(io_cycles),    64'(e.cycles));
            end
        end
        if (!io_done) done_seen = 1'b0;
    end

    task automatic set_hart(input int h, input logic [XL-1:0] v);
        io_tohost[h*XL +: XL] = v;
    endtask

    // Pulse start; returns at the negedge where the DUT is in its first RUN cycle (jc=0).
    task automatic start_run(input bit push, input exp_t e);
        io_start = 1'b1;
        if (push) exp_q.push_back(e);
        @(negedge clock);
        io_start = 1'b0;
        jc = 0;
    endtask

    task automatic goto_j(input int t);
        while (jc < t) begin
            @(negedge clock);
            jc++;
        end
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && !io_done; i++) @(negedge clock);
        chk("done_reached", 64'(io_done), 64'(1));
    endtask

    task automatic clear_run();
        io_clear = 1'b1;
        @(negedge clock);
        io_clear = 1'b0;
        io_tohost = '0;
        chk("idle_after_clear", 64'({io_done, io_busy}), 64'(0));
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"},   64'(io_busy),      64'(0));
        chk({tag, "_done"},   64'(io_done),      64'(0));
        chk({tag, "_passed"}, 64'(io_passed),    64'(0));
        chk({tag, "_tmo"},    64'(io_timeout),   64'(0));
        chk({tag, "_hdone"},  64'(io_hart_done), 64'(0));
        chk({tag, "_hfail"},  64'(io_hart_fail), 64'(0));
        chk({tag, "_fhart"},  64'(io_fail_hart), 64'(0));
        chk({tag, "_fcode"},  64'(io_fail_code), 64'(0));
        chk({tag, "_cycles"}, 64'(io_cycles),    64'(0));
    endtask

    initial begin
        exp_t e;
        repeat (2) @(negedge clock);
        check_all_zero("reset");
        reset_n = 1'b1;
        @(negedge clock);

        // R1: harts 0..3 pass at run cycles 3,5,7,9.
        e = '{passed:1, timeout:0, hdone:4'hF, hfail:0, fhart:0, fcode:0, cycles:10};
        start_run(1, e);
        chk("busy_after_start", 64'(io_busy), 64'(1));
        chk("cycles_at_start", 64'(io_cycles), 64'(0));
        goto_j(3); set_hart(0, 1);
        goto_j(5); set_hart(1, 1);
        goto_j(7); set_hart(2, 1);
        goto_j(9); set_hart(3, 1);
        wait_done(20);
        clear_run();

        // R2: hart 2 fails test 5 and hart 1 test 3 together; lowest index recorded.
        e = '{passed:0, timeout:0, hdone:4'hF, hfail:4'b0110, fhart:1, fcode:3, cycles:5};
        start_run(1, e);
        set_hart(0, 1);
        goto_j(2); set_hart(2, 32'h0000_000B); set_hart(1, 32'h0000_0007);
        goto_j(4); set_hart(3, 1);
        wait_done(20);
        clear_run();

        // R3: hart 3 never finishes -> watchdog after 100 RUN cycles.
        e = '{passed:0, timeout:1, hdone:4'b0111, hfail:0, fhart:0, fcode:0, cycles:100};
        start_run(1, e);
        goto_j(1); set_hart(0, 1); set_hart(1, 1); set_hart(2, 1);
        wait_done(150);
        clear_run();

        // R4: last hart completes on the watchdog cycle -> completion wins.
        e = '{passed:1, timeout:0, hdone:4'hF, hfail:0, fhart:0, fcode:0, cycles:100};
        start_run(1, e);
        goto_j(1); set_hart(0, 1); set_hart(1, 1); set_hart(2, 1);
        goto_j(99); set_hart(3, 1);
        wait_done(20);
        clear_run();

        // R5: hart 0 later rewrites a fail code (ignored); start during RUN ignored.
        e = '{passed:1, timeout:0, hdone:4'hF, hfail:0, fhart:0, fcode:0, cycles:6};
        start_run(1, e);
        set_hart(0, 1);
        goto_j(2); set_hart(0, 32'h0000_0009);
        goto_j(3); io_start = 1'b1;
        goto_j(4); io_start = 1'b0;
        chk("busy_after_start_in_run", 64'(io_busy), 64'(1));
        chk("cycles_unaffected_by_start", 64'(io_cycles), 64'(4));
        goto_j(5); set_hart(1, 1); set_hart(2, 1); set_hart(3, 1);
        wait_done(20);
        clear_run();

        // R6: reset mid-run discards everything.
        e = '{passed:0, timeout:0, hdone:0, hfail:0, fhart:0, fcode:0, cycles:0};
        start_run(0, e);
        set_hart(0, 32'h0000_0005);
        goto_j(3);
        chk("hdone_before_reset", 64'(io_hart_done), 64'(1));
        reset_n = 1'b0;
        @(negedge clock);
        check_all_zero("midrun_reset");
        reset_n = 1'b1;
        io_tohost = '0;
        @(negedge clock);

        // R7: clear ignored in RUN, start ignored in DONE.
        e = '{passed:1, timeout:0, hdone:4'hF, hfail:0, fhart:0, fcode:0, cycles:2};
        start_run(1, e);
        io_clear = 1'b1;
        goto_j(1); io_clear = 1'b0;
        chk("busy_after_clear_in_run", 64'(io_busy), 64'(1));
        set_hart(0, 1); set_hart(1, 1); set_hart(2, 1); set_hart(3, 1);
        wait_done(20);
        io_start = 1'b1;
        @(negedge clock);
        io_start = 1'b0;
        chk("done_after_start_in_done", 64'(io_done), 64'(1));
        chk("cycles_hold_in_done", 64'(io_cycles), 64'(2));
        io_tohost = '0;
        clear_run();
        chk("results_visible_in_idle", 64'(io_hart_done), 64'hF);

        // R8: rerun after clear; counter restarts from 0.
        e = '{passed:1, timeout:0, hdone:4'hF, hfail:0, fhart:0, fcode:0, cycles:1};
        start_run(1, e);
        chk("cycles_restart", 64'(io_cycles), 64'(0));
        chk("hdone_cleared_on_start", 64'(io_hart_done), 64'(0));
        set_hart(0, 1); set_hart(1, 1); set_hart(2, 1); set_hart(3, 1);
        wait_done(20);
        clear_run();

        repeat (2) @(negedge clock);
        chk("all_results_seen", 64'(exp_q.size()), 64'(0));
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
